pwm_start_sequencer: RTL

Sequencer that brings a group of PWM generator counter chains up and down in a controlled order. It starts the shared timebase, issues one synchronisation pulse and then enables each chain with a programmable stagger delay. It performs an orderly stop and a latched fault shutdown. It sits between the PWM control unit's register fields (start/stop/fault requests) and the per-chain counter_run, sync and timebase_enable inputs of the PWM generator.

---
 rtl/pwm_start_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_start_sequencer.sv
// Brings PWM counter chains up in a staggered order and down in an orderly or fault-driven way.
// Optional stop watchdog: define PWM_STOP_TIMEOUT_EN.
module pwm_start_sequencer #(
  parameter int unsigned N_CHAINS     = 3,
  parameter int unsigned DELAY_WIDTH  = 16,
  parameter int unsigned STOP_TIMEOUT = 1024
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   fault_i,
  input  logic                   fault_clear_i,
  input  logic [DELAY_WIDTH-1:0] stagger_delay_i,
  input  logic [N_CHAINS-1:0]    counter_status_i,
  output logic                   timebase_enable_o,
  output logic                   sync_o,
  output logic [N_CHAINS-1:0]    counter_run_o,
  output logic                   running_o,
  output logic                   busy_o,
  output logic                   fault_latched_o,
  output logic                   timeout_flag_o
);

  localparam int IW = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_CHAINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TB_START,
    S_SYNC,
    S_STAGGER,
    S_RUNNING,
    S_STOPPING,
    S_FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] dly_q, dly_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          idx_nx;
  logic [N_CHAINS-1:0]    run_q, run_d;
  logic                   tb_q, tb_d;
  logic                   sync_q, sync_d;
  logic                   running_q, running_d;
  logic                   busy_q;
  logic                   fl_q, fl_d;
  logic                   stoppable;

`ifdef PWM_STOP_TIMEOUT_EN
  localparam int WW = $clog2(STOP_TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          to_q, to_d;
`endif

  assign idx_nx    = idx_q + 1'b1;
  assign stoppable = (state_q == S_TB_START) || (state_q == S_SYNC) ||
                     (state_q == S_STAGGER)  || (state_q == S_RUNNING);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    run_d     = run_q;
    tb_d      = tb_q;
    sync_d    = 1'b0;
    running_d = running_q;
    fl_d      = fl_q;
`ifdef PWM_STOP_TIMEOUT_EN
    wd_d      = wd_q;
    to_d      = to_q;
`endif
    if (fault_i) begin
      state_d   = S_FAULT;
      run_d     = '0;
      tb_d      = 1'b0;
      running_d = 1'b0;
      fl_d      = 1'b1;
    end else if (stop_i && stoppable) begin
      state_d   = S_STOPPING;
      run_d     = '0;
      tb_d      = 1'b1;
      running_d = 1'b0;
`ifdef PWM_STOP_TIMEOUT_EN
      wd_d      = '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && !stop_i) begin
            state_d = S_TB_START;
            tb_d    = 1'b1;
            dly_d   = (stagger_delay_i == '0) ? DELAY_WIDTH'(1)
                                              : stagger_delay_i;
          end
        end
        S_TB_START: begin
          state_d = S_SYNC;
          sync_d  = 1'b1;
        end
        S_SYNC: begin
          run_d = N_CHAINS'(1);
          idx_d = '0;
          cnt_d = dly_q;
          if (N_CHAINS == 1) begin
            state_d   = S_RUNNING;
            running_d = 1'b1;
          end else begin
            state_d = S_STAGGER;
          end
        end
        S_STAGGER: begin
          // count reaches 1 exactly D cycles after the previous enable
          if (cnt_q == DELAY_WIDTH'(1)) begin
            idx_d = idx_nx;
            run_d = run_q | (N_CHAINS'(1) << idx_nx);
            cnt_d = dly_q;
            if (idx_nx == LAST) begin
              state_d   = S_RUNNING;
              running_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_RUNNING: ;
        S_STOPPING: begin
          if (counter_status_i == '0) begin
            state_d = S_IDLE;
            tb_d    = 1'b0;
          end
`ifdef PWM_STOP_TIMEOUT_EN
          else if (wd_q == WW'(STOP_TIMEOUT - 1)) begin
            state_d = S_FAULT;
            tb_d    = 1'b0;
            fl_d    = 1'b1;
            to_d    = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
`endif
        end
        S_FAULT: begin
          if (fault_clear_i) begin
            state_d = S_IDLE;
            fl_d    = 1'b0;
`ifdef PWM_STOP_TIMEOUT_EN
            to_d    = 1'b0;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      run_q     <= '0;
      tb_q      <= 1'b0;
      sync_q    <= 1'b0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
      fl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      tb_q      <= tb_d;
      sync_q    <= sync_d;
      running_q <= running_d;
      busy_q    <= (state_d != S_IDLE);
      fl_q      <= fl_d;
    end
  end

`ifdef PWM_STOP_TIMEOUT_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign timeout_flag_o = to_q;
`else
  assign timeout_flag_o = 1'b0;
`endif

  assign timebase_enable_o = tb_q;
  assign sync_o            = sync_q;
  assign counter_run_o     = run_q;
  assign running_o         = running_q;
  assign busy_o            = busy_q;
  assign fault_latched_o   = fl_q;

endmodule
